// File: rtl/config_pkg.sv
// Shared DDR request-interface types and responder defaults.
package config_pkg;

  localparam int unsigned DdrDataWidth = 32;
  localparam int unsigned DdrAddrWidth = 32;

  typedef logic [DdrAddrWidth-1:0] ddr_address_t;
  typedef logic [DdrDataWidth-1:0] ddr_data_t;

  localparam int unsigned DdrRespDepth      = 1024;
  localparam int unsigned DdrRespIndexWidth = $clog2(DdrRespDepth);

  typedef logic [DdrRespIndexWidth-1:0] ddr_resp_index_t;

  // One request beat as seen on the DDR request port.
  typedef struct packed {
    logic         r_en;
    logic         w_en;
    ddr_address_t address;
    ddr_data_t    data;
  } ddr_req_t;

endpackage

// File: rtl/ddr_resp_delay_line.sv
// Fixed-latency valid+payload shift register; Width=0 carries only the valid bit.
module ddr_resp_delay_line #(
  parameter int unsigned Width   = 1,
  parameter int unsigned Latency = 1,
  localparam int unsigned PayloadWidth = (Width == 0) ? 1 : Width
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [PayloadWidth-1:0] data_i,
  output logic                    valid_o,
  output logic [PayloadWidth-1:0] data_o
);

  logic [Latency-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int unsigned i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Latency-1];

  generate
    if (Width > 0) begin : g_payload
      logic [PayloadWidth-1:0] data_q [Latency];

      // Stages only load behind a valid beat, so the tail holds the last delivered word.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int unsigned i = 0; i < Latency; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          if (valid_i) begin
            data_q[0] <= data_i;
          end
          for (int unsigned i = 1; i < Latency; i++) begin
            if (valid_q[i-1]) begin
              data_q[i] <= data_q[i-1];
            end
          end
        end
      end

      assign data_o = data_q[Latency-1];
    end else begin : g_no_payload
      logic unused_data;
      assign unused_data = ^data_i;
      assign data_o      = '0;
    end
  endgenerate

endmodule

// File: rtl/ddr_memory_responder.sv
// Word-addressed DDR stand-in with fixed read/write response latencies.
// Optional DDR_RESP_PROTOCOL_CHECK_EN adds the sticky ddr_err_o protocol checker.
module ddr_memory_responder
  import config_pkg::*;
#(
  parameter int unsigned DdrDepth     = DdrRespDepth,
  parameter int unsigned ReadLatency  = 2,
  parameter int unsigned WriteLatency = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  ddr_address_t ddr_address_i,
  input  logic         ddr_r_en_i,
  output ddr_data_t    ddr_r_data_o,
  output logic         ddr_r_valid_o,
  input  logic         ddr_w_en_i,
  input  ddr_data_t    ddr_w_data_i,
  output logic         ddr_w_done_o
`ifdef DDR_RESP_PROTOCOL_CHECK_EN
  ,
  output logic         ddr_err_o
`endif
);

  localparam int unsigned IdxW = $clog2(DdrDepth);

  ddr_req_t        req;
  logic [IdxW-1:0] index;
  logic            wr_accept;
  logic            rd_accept;
  ddr_data_t       rd_word;
  ddr_data_t       mem [DdrDepth];
  logic            unused_done_data;

  assign req = '{
    r_en:    ddr_r_en_i,
    w_en:    ddr_w_en_i,
    address: ddr_address_i,
    data:    ddr_w_data_i
  };

  assign index = req.address[IdxW-1:0];

  // A write in the same cycle as a read takes precedence and swallows the read.
  assign wr_accept = req.w_en;
  assign rd_accept = req.r_en & ~req.w_en;

  always_ff @(posedge clk_i) begin
    if (wr_accept && !rst_i) begin
      mem[index] <= req.data;
    end
  end

  assign rd_word = mem[index];

  ddr_resp_delay_line #(
    .Width   (DdrDataWidth),
    .Latency (ReadLatency)
  ) u_read_line (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rd_accept),
    .data_i  (rd_word),
    .valid_o (ddr_r_valid_o),
    .data_o  (ddr_r_data_o)
  );

  ddr_resp_delay_line #(
    .Width   (0),
    .Latency (WriteLatency)
  ) u_write_line (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (wr_accept),
    .data_i  (1'b0),
    .valid_o (ddr_w_done_o),
    .data_o  (unused_done_data)
  );

`ifdef DDR_RESP_PROTOCOL_CHECK_EN
  logic out_of_range;
  logic violation;

  assign out_of_range = |req.address[DdrAddrWidth-1:IdxW];
  assign violation    = (req.r_en & req.w_en) | ((req.r_en | req.w_en) & out_of_range);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ddr_err_o <= 1'b0;
    end else if (violation) begin
      ddr_err_o <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req.address[DdrAddrWidth-1:IdxW];
`endif

endmodule
